fft32_mul_share_arb: RTL and testbench

- Time-shares one 16x22-bit unsigned multiplier among NUM_REQ requesters inside the fft32 datapath, e.g. the butterfly twiddle-multiply ports.
- Round-robin arbiter, operand mux, combinational multiply and a one-deep registered result stage with valid/ready backpressure.
- Each result is tagged with the index of the requester that issued it, so consumers can demultiplex.

---
 rtl/fft32_mul_share_arb.sv | 107 ++++++++++
 tb/tb_fft32_mul_share_arb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fft32_mul_share_arb.sv
// Round-robin shared 16x22 unsigned multiplier for the fft32 datapath.
// One registered result stage with valid/ready backpressure; each result carries its requester id.
module fft32_mul_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 22,
    parameter int dout_WIDTH = 37
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*din0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*din1_WIDTH-1:0]    req_din1,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [dout_WIDTH-1:0]            res_dout,
    output logic [ID_W-1:0]                  res_id,
    output logic [15:0]                      busy_cnt
);

    localparam int PROD_W = din0_WIDTH + din1_WIDTH;

    logic [din0_WIDTH-1:0] din0_arr [NUM_REQ];
    logic [din1_WIDTH-1:0] din1_arr [NUM_REQ];

    logic                  res_valid_q, res_valid_d;
    logic [dout_WIDTH-1:0] res_dout_q, res_dout_d;
    logic [ID_W-1:0]       res_id_q, res_id_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [15:0]           busy_q, busy_d;

    logic                  any_valid;
    logic [ID_W-1:0]       grant_id;
    logic                  can_issue;
    logic                  accept;
    logic [PROD_W-1:0]     prod_full;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign din0_arr[gi] = req_din0[gi*din0_WIDTH +: din0_WIDTH];
            assign din1_arr[gi] = req_din1[gi*din1_WIDTH +: din1_WIDTH];
        end
    endgenerate

    // Scan offsets from farthest to nearest so the nearest valid requester after rr_ptr wins.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        grant_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                any_valid = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    assign can_issue = !res_valid_q || res_ready;
    assign accept    = any_valid && can_issue && !ap_rst;
    assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;

    always_comb begin
        prod_full = PROD_W'(din0_arr[grant_id]) * PROD_W'(din1_arr[grant_id]);
    end

    always_comb begin
        res_valid_d = res_valid_q && !res_ready;
        res_dout_d  = res_dout_q;
        res_id_d    = res_id_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        if (accept) begin
            res_valid_d = 1'b1;
            res_dout_d  = prod_full[dout_WIDTH-1:0];
            res_id_d    = grant_id;
            rr_ptr_d    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            if (busy_q != 16'hFFFF) busy_d = busy_q + 16'd1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            res_valid_q <= 1'b0;
            res_dout_q  <= '0;
            res_id_q    <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_dout_q  <= res_dout_d;
            res_id_q    <= res_id_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_dout  = res_dout_q;
    assign res_id    = res_id_q;
    assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_fft32_mul_share_arb.sv
// Directed test of fft32_mul_share_arb with hand-computed expectations and immediate assertions.
module tb_fft32_mul_share_arb;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_din0 = '0;
    logic [87:0] req_din1 = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [36:0] res_dout;
    logic [1:0]  res_id;
    logic [15:0] busy_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    longint exp_prod [4] = '{10, 40, 90, 160};

    fft32_mul_share_arb dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_din0 (req_din0),
        .req_din1 (req_din1),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_dout (res_dout),
        .res_id   (res_id),
        .busy_cnt (busy_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_ops(input int slot, input logic [15:0] a, input logic [21:0] b);
        req_din0[slot*16 +: 16] = a;
        req_din1[slot*22 +: 22] = b;
    endtask

    initial begin
        // Reset state
        #2 ap_rst = 1'b1;
        #1;
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_dout",  64'(res_dout),  64'd0);
        chk("rst_id",    64'(res_id),    64'd0);
        chk("rst_busy",  64'(busy_cnt),  64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        step();

        // Single requester 2: 3 x 5
        set_ops(2, 16'h0003, 22'h000005);
        req_valid = 4'b0100;
        res_ready = 1'b1;
        #1;
        chk("single_ready", 64'(req_ready), 64'h4);
        step();
        req_valid = 4'b0000;
        chk("single_valid", 64'(res_valid), 64'd1);
        chk("single_dout",  64'(res_dout),  64'd15);
        chk("single_id",    64'(res_id),    64'd2);
        chk("single_busy",  64'(busy_cnt),  64'd1);

        // Max operands on requester 3 (pointer sits at 3 after the previous grant)
        set_ops(3, 16'hFFFF, 22'h3FFFFF);
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0000;
        chk("max_dout", 64'(res_dout), 64'h1F_FFBF_0001);
        chk("max_id",   64'(res_id),   64'd3);
        chk("max_busy", 64'(busy_cnt), 64'd2);

        // Drain: no requester, consumer ready
        step();
        chk("drain_valid", 64'(res_valid), 64'd0);
        chk("drain_dout",  64'(res_dout),  64'h1F_FFBF_0001);
        chk("drain_id",    64'(res_id),    64'd3);

        // All four valid for 8 cycles: round-robin 0,1,2,3,0,1,2,3
        for (int i = 0; i < 4; i++) set_ops(i, 16'(i + 1), 22'(10 * (i + 1)));
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr_ready_%0d", i), 64'(req_ready), 64'(4'b0001 << (i % 4)));
            step();
            chk($sformatf("rr_id_%0d", i),   64'(res_id),   64'(i % 4));
            chk($sformatf("rr_dout_%0d", i), 64'(res_dout), 64'(exp_prod[i % 4]));
            chk($sformatf("rr_valid_%0d", i), 64'(res_valid), 64'd1);
        end
        chk("rr_busy", 64'(busy_cnt), 64'd10);

        // Pointer fairness: req 3 alone, then req 0 and 3 together -> 0 first
        req_valid = 4'b1000;
        step();
        chk("fair_id3", 64'(res_id), 64'd3);
        req_valid = 4'b1001;
        #1;
        chk("fair_ready", 64'(req_ready), 64'h1);
        step();
        chk("fair_id0",   64'(res_id),   64'd0);
        chk("fair_dout0", 64'(res_dout), 64'd10);
        chk("fair_busy",  64'(busy_cnt), 64'd12);

        // Backpressure: hold res_ready low for 3 cycles with req 1 pending
        req_valid = 4'b0010;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_ready_%0d", i), 64'(req_ready), 64'd0);
            step();
            chk($sformatf("bp_valid_%0d", i), 64'(res_valid), 64'd1);
            chk($sformatf("bp_dout_%0d", i),  64'(res_dout),  64'd10);
            chk($sformatf("bp_id_%0d", i),    64'(res_id),    64'd0);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'h2);
        step();
        chk("bp_next_valid", 64'(res_valid), 64'd1);
        chk("bp_next_dout",  64'(res_dout),  64'd40);
        chk("bp_next_id",    64'(res_id),    64'd1);
        chk("bp_busy",       64'(busy_cnt),  64'd13);

        // Async reset mid-stream while a result is held
        req_valid = 4'b0000;
        res_ready = 1'b0;
        #2 ap_rst = 1'b1;
        #1;
        chk("arst_valid", 64'(res_valid), 64'd0);
        chk("arst_dout",  64'(res_dout),  64'd0);
        chk("arst_id",    64'(res_id),    64'd0);
        chk("arst_busy",  64'(busy_cnt),  64'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        req_valid = 4'b1010;
        res_ready = 1'b1;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'h2);
        step();
        chk("post_rst_id",   64'(res_id),   64'd1);
        chk("post_rst_dout", 64'(res_dout), 64'd40);
        chk("post_rst_busy", 64'(busy_cnt), 64'd1);
        req_valid = 4'b0000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
